// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module : cpu_pkg
// Brief  : Shared types and constants for the MIPS fetch controller.
// Rev    : 1.0 - initial release
// ============================================================================
package cpu_pkg;

    localparam int          CPU_ADDR_W   = 32;
    localparam int          CPU_DATA_W   = 32;
    localparam logic [31:0] CPU_RESET_PC = 32'h0000_0000;
    localparam int          WORD_INC     = 4;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        REQ   = 3'd1,
        WAIT  = 3'd2,
        DRAIN = 3'd3,
        HOLD  = 3'd4
    } fetch_state_t;

    typedef enum logic [1:0] {
        PC_HOLD   = 2'd0,
        PC_INC    = 2'd1,
        PC_TARGET = 2'd2
    } pc_sel_t;

endpackage
`default_nettype wire

// File: rtl/fetch_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module : fetch_ctrl_if
// Brief  : Instruction-memory, decode and redirect signals of the fetch stage.
// Rev    : 1.0 - initial release
// ============================================================================
interface fetch_ctrl_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              pcsrc;
    logic [ADDR_W-1:0] branch_target;
    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_gnt;
    logic              imem_rvalid;
    logic [DATA_W-1:0] imem_rdata;
    logic              out_valid;
    logic [DATA_W-1:0] out_instr;
    logic [ADDR_W-1:0] out_pc4;
    logic              dec_ready;

    modport master (
        input  pcsrc, branch_target, imem_gnt, imem_rvalid, imem_rdata, dec_ready,
        output imem_req, imem_addr, out_valid, out_instr, out_pc4
    );

    modport slave (
        output pcsrc, branch_target, imem_gnt, imem_rvalid, imem_rdata, dec_ready,
        input  imem_req, imem_addr, out_valid, out_instr, out_pc4
    );
endinterface
`default_nettype wire

// File: rtl/pc_next_mux.sv
`default_nettype none
// ============================================================================
// Module : pc_next_mux
// Brief  : Next-PC select: hold, sequential increment or word-aligned target.
// Rev    : 1.0 - initial release
// ============================================================================
module pc_next_mux
    import cpu_pkg::*;
#(
    parameter int ADDR_W = CPU_ADDR_W
) (
    input  wire logic [ADDR_W-1:0] pc,
    input  wire logic [ADDR_W-1:0] target,
    input  wire pc_sel_t           sel,
    output logic      [ADDR_W-1:0] pc_next
);

    logic [ADDR_W-1:0] w_inc;
    logic [ADDR_W-1:0] w_tgt;

    // Increment wraps naturally; target low bits are forced to a word boundary.
    assign w_inc = pc + ADDR_W'(WORD_INC);
    assign w_tgt = target & ~ADDR_W'(3);

    always_comb begin
        pc_next = pc;
        case (sel)
            PC_INC:    pc_next = w_inc;
            PC_TARGET: pc_next = w_tgt;
            default:   pc_next = pc;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module : fetch_ctrl
// Brief  : PC owner and fetch sequencer between instruction memory and decode.
// Rev    : 1.0 - initial release
// ============================================================================
module fetch_ctrl
    import cpu_pkg::*;
#(
    parameter int                ADDR_W   = CPU_ADDR_W,
    parameter int                DATA_W   = CPU_DATA_W,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(CPU_RESET_PC)
) (
    input  wire logic     clk,
    input  wire logic     rst_n,
    fetch_ctrl_if.master  bus
);

    fetch_state_t      r_state;
    fetch_state_t      w_state_nxt;
    pc_sel_t           w_pc_sel;
    logic              w_capture;
    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] w_pc_next;
    logic              r_imem_req;
    logic              r_out_valid;
    logic [DATA_W-1:0] r_out_instr;
    logic [ADDR_W-1:0] r_out_pc4;

    pc_next_mux #(.ADDR_W(ADDR_W)) u_pc_next_mux (
        .pc      (r_pc),
        .target  (bus.branch_target),
        .sel     (w_pc_sel),
        .pc_next (w_pc_next)
    );

    // A redirect always wins the PC; only the state transition depends on the bus.
    always_comb begin
        w_state_nxt = r_state;
        w_pc_sel    = bus.pcsrc ? PC_TARGET : PC_HOLD;
        w_capture   = 1'b0;
        case (r_state)
            IDLE: w_state_nxt = REQ;
            REQ: begin
                if (bus.imem_gnt) w_state_nxt = bus.pcsrc ? DRAIN : WAIT;
            end
            WAIT: begin
                if (bus.imem_rvalid) begin
                    if (bus.pcsrc) begin
                        w_state_nxt = REQ;
                    end else begin
                        w_state_nxt = HOLD;
                        w_pc_sel    = PC_INC;
                        w_capture   = 1'b1;
                    end
                end else if (bus.pcsrc) begin
                    w_state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (bus.imem_rvalid) w_state_nxt = REQ;
            end
            HOLD: begin
                if (bus.pcsrc || bus.dec_ready) w_state_nxt = REQ;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Handshake outputs are registered from the next state so they align with it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_pc        <= RESET_PC;
            r_imem_req  <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_instr <= '0;
            r_out_pc4   <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_pc        <= w_pc_next;
            r_imem_req  <= (w_state_nxt == REQ);
            r_out_valid <= (w_state_nxt == HOLD);
            if (w_capture) begin
                r_out_instr <= bus.imem_rdata;
                r_out_pc4   <= w_pc_next;
            end
        end
    end

    assign bus.imem_req  = r_imem_req;
    assign bus.imem_addr = r_pc;
    assign bus.out_valid = r_out_valid;
    assign bus.out_instr = r_out_instr;
    assign bus.out_pc4   = r_out_pc4;

endmodule
`default_nettype wire

// File: tb/tb_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module : tb_fetch_ctrl
// Brief  : Directed and randomized self-checking bench for fetch_ctrl.
// Rev    : 1.0 - initial release
// ============================================================================
module tb_fetch_ctrl;

    localparam int          ADDR_W = 32;
    localparam int          DATA_W = 32;
    localparam logic [31:0] RST_PC = 32'h0000_0000;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;

    fetch_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    fetch_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RESET_PC(RST_PC)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Memory content used by the randomized run: a fixed hash of the word address.
    function automatic logic [31:0] memf(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
    endfunction

    task automatic cyc(input logic g, input logic rv, input logic [31:0] rd,
                       input logic pc, input logic [31:0] tg, input logic dr);
        bus.imem_gnt      = g;
        bus.imem_rvalid   = rv;
        bus.imem_rdata    = rd;
        bus.pcsrc         = pc;
        bus.branch_target = tg;
        bus.dec_ready     = dr;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        cyc(0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0);
        n_checks++; if (bus.imem_req !== 1'b0) begin n_fail++; $display("FAIL reset_req got=%b exp=0", bus.imem_req); end
        n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%b exp=0", bus.out_valid); end
        n_checks++; if (bus.out_instr !== 32'h0) begin n_fail++; $display("FAIL reset_instr got=%h exp=0", bus.out_instr); end
        n_checks++; if (bus.out_pc4 !== 32'h0) begin n_fail++; $display("FAIL reset_pc4 got=%h exp=0", bus.out_pc4); end
        n_checks++; if (bus.imem_addr !== RST_PC) begin n_fail++; $display("FAIL reset_addr got=%h exp=%h", bus.imem_addr, RST_PC); end
        rst_n = 1'b1;
        cyc(0, 0, 0, 0, 0, 0);
        n_checks++; if (bus.imem_req !== 1'b1) begin n_fail++; $display("FAIL first_req got=%b exp=1", bus.imem_req); end
    endtask

    task automatic test_basic_fetch();
        n_checks++; if (bus.imem_addr !== 32'h0) begin n_fail++; $display("FAIL basic_addr got=%h exp=0", bus.imem_addr); end
        cyc(1, 0, 0, 0, 0, 1);
        cyc(0, 1, 32'h2002_0005, 0, 0, 1);
        n_checks++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL basic_valid got=%b exp=1", bus.out_valid); end
        n_checks++; if (bus.out_instr !== 32'h2002_0005) begin n_fail++; $display("FAIL basic_instr got=%h exp=20020005", bus.out_instr); end
        n_checks++; if (bus.out_pc4 !== 32'h4) begin n_fail++; $display("FAIL basic_pc4 got=%h exp=4", bus.out_pc4); end
        cyc(0, 0, 0, 0, 0, 1);
        n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL basic_valid_drop got=%b exp=0", bus.out_valid); end
        n_checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h4) begin n_fail++; $display("FAIL basic_next req=%b addr=%h exp req=1 addr=4", bus.imem_req, bus.imem_addr); end
    endtask

    task automatic test_hold_stall();
        cyc(1, 0, 0, 0, 0, 0);
        cyc(0, 1, 32'hCAFE_0001, 0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            cyc(0, 0, 0, 0, 0, 0);
            n_checks++;
            if (bus.out_valid !== 1'b1 || bus.out_instr !== 32'hCAFE_0001 || bus.out_pc4 !== 32'h8 || bus.imem_req !== 1'b0) begin
                n_fail++;
                $display("FAIL hold_stable cyc=%0d valid=%b instr=%h pc4=%h req=%b exp 1/cafe0001/8/0", i, bus.out_valid, bus.out_instr, bus.out_pc4, bus.imem_req);
            end
        end
        cyc(0, 0, 0, 0, 0, 1);
        n_checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h8) begin n_fail++; $display("FAIL hold_release req=%b addr=%h exp req=1 addr=8", bus.imem_req, bus.imem_addr); end
    endtask

    task automatic test_redirect_wait();
        cyc(1, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 1, 32'h40, 0);
        cyc(0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0);
        n_checks++; if (bus.imem_req !== 1'b0 || bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL drain_idle req=%b valid=%b exp 0/0", bus.imem_req, bus.out_valid); end
        cyc(0, 1, 32'hDEAD_BEEF, 0, 0, 1);
        n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL drain_discard got=%b exp=0", bus.out_valid); end
        n_checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h40) begin n_fail++; $display("FAIL drain_next req=%b addr=%h exp req=1 addr=40", bus.imem_req, bus.imem_addr); end
    endtask

    task automatic test_redirect_same_cycle();
        cyc(1, 0, 0, 1, 32'h100, 0);
        n_checks++; if (bus.imem_req !== 1'b0) begin n_fail++; $display("FAIL gnt_pcsrc_req got=%b exp=0", bus.imem_req); end
        cyc(0, 1, 32'h1111_1111, 0, 0, 1);
        n_checks++; if (bus.out_valid !== 1'b0 || bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h100) begin n_fail++; $display("FAIL gnt_pcsrc_next valid=%b req=%b addr=%h exp 0/1/100", bus.out_valid, bus.imem_req, bus.imem_addr); end
        cyc(1, 0, 0, 0, 0, 1);
        cyc(0, 1, 32'h2222_2222, 1, 32'h103, 1);
        n_checks++; if (bus.out_valid !== 1'b0 || bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h100) begin n_fail++; $display("FAIL rvalid_pcsrc valid=%b req=%b addr=%h exp 0/1/100", bus.out_valid, bus.imem_req, bus.imem_addr); end
    endtask

    task automatic test_wrap();
        cyc(0, 0, 0, 1, 32'hFFFF_FFFC, 0);
        n_checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL wrap_addr req=%b addr=%h exp 1/fffffffc", bus.imem_req, bus.imem_addr); end
        cyc(1, 0, 0, 0, 0, 0);
        cyc(0, 1, 32'h0BAD_F00D, 0, 0, 0);
        n_checks++; if (bus.out_valid !== 1'b1 || bus.out_pc4 !== 32'h0 || bus.out_instr !== 32'h0BAD_F00D) begin n_fail++; $display("FAIL wrap_pc4 valid=%b pc4=%h instr=%h exp 1/0/0badf00d", bus.out_valid, bus.out_pc4, bus.out_instr); end
        cyc(0, 0, 0, 0, 0, 1);
        n_checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h0) begin n_fail++; $display("FAIL wrap_next req=%b addr=%h exp 1/0", bus.imem_req, bus.imem_addr); end
    endtask

    task automatic test_async_reset();
        cyc(0, 0, 0, 1, 32'h200, 0);
        cyc(1, 0, 0, 0, 0, 0);
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++; if (bus.imem_addr !== RST_PC || bus.imem_req !== 1'b0 || bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL async_reset addr=%h req=%b valid=%b exp %h/0/0", bus.imem_addr, bus.imem_req, bus.out_valid, RST_PC); end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc(0, 1, 32'h5555_AAAA, 0, 0, 1);
        n_checks++; if (bus.out_valid !== 1'b0 || bus.imem_req !== 1'b1 || bus.imem_addr !== RST_PC) begin n_fail++; $display("FAIL stale_idle valid=%b req=%b addr=%h exp 0/1/%h", bus.out_valid, bus.imem_req, bus.imem_addr, RST_PC); end
        cyc(0, 1, 32'h5555_AAAA, 0, 0, 1);
        n_checks++; if (bus.out_valid !== 1'b0 || bus.imem_req !== 1'b1 || bus.imem_addr !== RST_PC) begin n_fail++; $display("FAIL stale_req valid=%b req=%b addr=%h exp 0/1/%h", bus.out_valid, bus.imem_req, bus.imem_addr, RST_PC); end
    endtask

    // Reference: the next instruction handed to decode must come from exp_pc,
    // which is the latest redirect target (word aligned) advanced by 4 per transfer.
    task automatic test_random();
        logic [31:0] exp_pc;
        logic [31:0] oaddr;
        logic [31:0] rd;
        logic [31:0] tg;
        logic        outst;
        logic        g, rv, pc, dr;
        int          cd;
        int          n_xfer;
        rst_n = 1'b0;
        cyc(0, 0, 0, 0, 0, 0);
        rst_n = 1'b1;
        exp_pc = RST_PC;
        outst  = 1'b0;
        oaddr  = '0;
        cd     = 0;
        n_xfer = 0;
        for (int c = 0; c < 3000; c++) begin
            rv = 1'b0;
            rd = $urandom;
            if (outst) begin
                if (cd == 0) begin
                    rv    = 1'b1;
                    rd    = memf(oaddr);
                    outst = 1'b0;
                end else begin
                    cd--;
                end
            end
            g = ($urandom_range(0, 9) < 7);
            if (bus.imem_req && g) begin
                if (outst) begin
                    n_checks++; n_fail++;
                    $display("FAIL rand_outstanding cyc=%0d second grant while response pending", c);
                end
                n_checks++; if (bus.imem_addr[1:0] !== 2'b00) begin n_fail++; $display("FAIL rand_align cyc=%0d addr=%h exp low bits 00", c, bus.imem_addr); end
                outst = 1'b1;
                oaddr = bus.imem_addr;
                cd    = $urandom_range(0, 3);
            end
            pc = ($urandom_range(0, 11) == 0);
            if ($urandom_range(0, 3) == 0) tg = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
            else                           tg = 32'($urandom_range(0, 4095));
            dr = ($urandom_range(0, 9) < 6);
            if (bus.out_valid && bus.imem_req) begin
                n_checks++; n_fail++;
                $display("FAIL rand_exclusive cyc=%0d out_valid and imem_req both high", c);
            end
            if (bus.out_valid && dr && !pc) begin
                n_checks++;
                if (bus.out_instr !== memf(exp_pc) || bus.out_pc4 !== exp_pc + 32'd4) begin
                    n_fail++;
                    $display("FAIL rand_xfer cyc=%0d instr=%h pc4=%h exp instr=%h pc4=%h", c, bus.out_instr, bus.out_pc4, memf(exp_pc), exp_pc + 32'd4);
                end
                exp_pc = exp_pc + 32'd4;
                n_xfer++;
            end
            if (pc) exp_pc = tg & ~32'd3;
            cyc(g, rv, rd, pc, tg, dr);
        end
        n_checks++; if (n_xfer < 50) begin n_fail++; $display("FAIL rand_progress transfers=%0d exp>=50", n_xfer); end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        bus.imem_gnt      = 1'b0;
        bus.imem_rvalid   = 1'b0;
        bus.imem_rdata    = '0;
        bus.pcsrc         = 1'b0;
        bus.branch_target = '0;
        bus.dec_ready     = 1'b0;
        test_reset();
        test_basic_fetch();
        test_hold_stall();
        test_redirect_wait();
        test_redirect_same_cycle();
        test_wrap();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
